// File: rtl/lfsr_byte_packer.sv
// lfsr_byte_packer
//   Packs IN_BITS-wide LFSR chunks MSB-first into a continuous bit stream,
//   re-slices the stream into OUT_WIDTH-bit words and buffers them in a small
//   circular FIFO behind a valid/ready output. in_ready is meant to drive the
//   LFSR enable so that backpressure stalls generation instead of losing bits.
//
// Ports
//   clk         sole clock, rising edge
//   reset       asynchronous active-high reset of all state
//   clear       synchronous clear of all state (same effect as reset)
//   in_data     chunk from the LFSR
//   in_valid    chunk present
//   in_ready    packer can absorb a beat this cycle
//   flush       one-cycle request to zero-pad and emit a partial word
//   out_data    FIFO head word (0 when empty)
//   out_valid   FIFO non-empty
//   out_ready   consumer accepts the head word
//   fill_level  bits currently held in the accumulator
//   word_count  words pushed into the FIFO, wraps modulo 2^16
//   overflow    sticky: a beat arrived while in_ready was low
module lfsr_byte_packer #(
  parameter int unsigned IN_BITS    = 6,
  parameter int unsigned OUT_WIDTH  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic [IN_BITS-1:0]           in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         flush,
  output logic [OUT_WIDTH-1:0]         out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(OUT_WIDTH):0]   fill_level,
  output logic [15:0]                  word_count,
  output logic                         overflow
);

  localparam int unsigned ACC_W  = OUT_WIDTH + IN_BITS - 1;
  localparam int unsigned FILL_W = $clog2(OUT_WIDTH) + 1;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;

  logic [ACC_W-1:0]     acc;
  logic [FILL_W-1:0]    fill;
  logic                 flush_pending;

  logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;

  logic                 space;
  logic                 beat;
  logic                 flush_exec;
  logic                 push;
  logic                 pop;
  logic [ACC_W-1:0]     acc_beat;
  logic [FILL_W-1:0]    fill_sum;
  logic                 word_done;
  logic [OUT_WIDTH-1:0] beat_word;
  logic [OUT_WIDTH-1:0] flush_word;
  logic [OUT_WIDTH-1:0] push_word;

  always_comb begin
    space     = count < CNT_W'(FIFO_DEPTH);
    beat      = in_valid & in_ready;
    acc_beat  = ACC_W'({acc, in_data});
    fill_sum  = fill + FILL_W'(IN_BITS);
    word_done = fill_sum >= FILL_W'(OUT_WIDTH);
    // Stale bits above the valid window fall off the top when truncated to
    // OUT_WIDTH, so neither word needs an explicit mask.
    beat_word  = OUT_WIDTH'(acc_beat >> (fill_sum - FILL_W'(OUT_WIDTH)));
    flush_word = OUT_WIDTH'(acc << (FILL_W'(OUT_WIDTH) - fill));
    // A pending flush yields to an accepted beat so the beat's bits land in
    // the padded word.
    flush_exec = flush_pending & ~beat & space;
    push       = (beat & word_done) | (flush_exec & (fill != '0));
    push_word  = beat ? beat_word : flush_word;
    pop        = (count != '0) & out_ready;
  end

  assign in_ready   = space & ~clear;
  assign out_valid  = count != '0;
  assign out_data   = out_valid ? mem[rd_ptr] : '0;
  assign fill_level = fill;

  // Storage needs no reset: the head is gated by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_word;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc           <= '0;
      fill          <= '0;
      flush_pending <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      word_count    <= '0;
      overflow      <= 1'b0;
    end else if (clear) begin
      acc           <= '0;
      fill          <= '0;
      flush_pending <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      word_count    <= '0;
      overflow      <= 1'b0;
    end else begin
      if (in_valid & ~in_ready) begin
        overflow <= 1'b1;
      end

      if (beat) begin
        acc  <= acc_beat;
        fill <= word_done ? fill_sum - FILL_W'(OUT_WIDTH) : fill_sum;
      end else if (flush_exec) begin
        fill <= '0;
      end

      flush_pending <= flush | (flush_pending & ~flush_exec);

      if (push) begin
        wr_ptr     <= wr_ptr + PTR_W'(1);
        word_count <= word_count + 16'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/lfsr_byte_packer.md
# lfsr_byte_packer

Downstream stage for `galois_lfsr`. It accepts the LFSR's `IN_BITS`-wide output chunk on every valid beat and concatenates the chunks MSB-first into a continuous bit stream. The stream is re-sliced into `OUT_WIDTH`-bit words, which are buffered in a small FIFO and presented on a valid/ready interface for bus or UART consumers. `in_ready` is intended to drive the LFSR `enable`, so that backpressure stalls generation instead of losing bits.

## Interface

Parameters:
- `IN_BITS`, default 6: chunk width per input beat. Legal range is 1..`OUT_WIDTH`.
- `OUT_WIDTH`, default 8: output word width.
- `FIFO_DEPTH`, default 4: output FIFO entries. Must be a power of two, ≥ 2.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  sole clock; all state is updated on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `clear`  in  1  synchronous clear of all state; same effect as `reset`.
- `in_data`  in  `IN_BITS`  chunk from the LFSR `out`.
- `in_valid`  in  1  chunk present; connected to LFSR `valid`.
- `in_ready`  out  1  packer can absorb a beat this cycle.
- `flush`  in  1  one-cycle request to zero-pad and emit a partial word.
- `out_data`  out  `OUT_WIDTH`  FIFO head word.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts the head word.
- `fill_level`  out  $clog2(`OUT_WIDTH`)+1  bits currently held in the accumulator.
- `word_count`  out  16  words pushed into the FIFO; wraps modulo 2^16.
- `overflow`  out  1  sticky flag: a beat arrived while `in_ready`=0.

## Operation

- **Accumulator:**
  - Width is `OUT_WIDTH`+`IN_BITS`−1 bits; `fill` ranges 0..`OUT_WIDTH`−1.
  - On an accepted beat (`in_valid`&`in_ready`): acc = (acc<<`IN_BITS`)|`in_data`, and `fill` += `IN_BITS`.
  - If the new `fill` ≥ `OUT_WIDTH`, push word = acc[fill−1 -: `OUT_WIDTH`] (oldest bits become MSBs), then `fill` −= `OUT_WIDTH`.
  - Because `IN_BITS` ≤ `OUT_WIDTH`, at most one word is produced per beat.
- **`in_ready`:** equals (FIFO count < `FIFO_DEPTH`) & !`clear`. It is combinational from registered state only, so it does not depend on `out_ready`.
- **Dropped beat:** when `in_valid`=1 and `in_ready`=0, the beat is discarded, `overflow` is set to 1, and the accumulator is unchanged.
- **Flush:**
  - A `flush` pulse sets `flush_pending`.
  - The pending flush executes on the first cycle that has no accepted beat and FIFO space available.
  - If `fill`>0: push acc[fill−1:0]<<(`OUT_WIDTH`−`fill`) (zero-padded LSBs), then set `fill`=0. If `fill`=0: no push.
  - `flush_pending` clears on execution.
  - A flush that coincides with an accepted beat waits, so the beat's bits are included in the padded word.
- **FIFO:**
  - Circular buffer with read/write pointers and a count.
  - Pop on `out_valid`&`out_ready`. Simultaneous push and pop leaves the count unchanged.
  - `out_data` is the registered head entry. Its value is don't-care when empty; the implementation drives 0.
- **`word_count`:** increments once per push, including flush pushes.
- **Clear priority:** `reset` > `clear` > flush/beat. `clear` empties the FIFO and accumulator and zeroes `overflow`, `word_count` and `flush_pending`.

## Timing

- **Reset values:** `out_valid`=0, `out_data`=0, `in_ready`=1, `fill_level`=0, `word_count`=0, `overflow`=0.
- **Latency:** a beat that completes a word at edge N gives `out_valid`=1 with that word after edge N. The word is visible in cycle N+1, a one-cycle latency into an empty FIFO. Flush has the same latency from the cycle it executes.
- **Full FIFO:** a pop in cycle N frees a slot, and `in_ready` rises in cycle N+1.
- **Output stability:** `out_data`/`out_valid` hold steady while `out_valid`=1 and `out_ready`=0.
- **Reset mid-stream:** a `reset` assertion between edges zeroes all outputs immediately. Any partial word is lost, and the first beat after deassertion starts at bit 0.

## Test plan

1. **Packing order.** Stimulus: `IN_BITS`=6, `OUT_WIDTH`=8, `out_ready`=1; beats 6'b101010, 6'b110011, 6'b000111, 6'b111100. Required response:
   - words 0xAB after beat 2, 0x31 after beat 3, 0xFC after beat 4, each one cycle after its completing beat;
   - `fill_level` sequence 6, 4, 2, 0;
   - `word_count`=3.
2. **Flush padding.** Stimulus: beat 6'b111111, then a `flush` pulse. Required response: one word 0xFC; `fill_level` returns to 0.
3. **Flush with a coincident beat.** Stimulus: beat 6'b101010 with `flush` in the same cycle. Required response: the beat is absorbed first, then a single 0xA8 is pushed the next cycle.
4. **Backpressure and overflow.** Stimulus: `out_ready`=0; stream beats until the FIFO holds 4 words (`in_ready`=0); drive one extra beat. Required response:
   - `overflow`=1 and the beat is dropped;
   - after `out_ready`=1, words drain in order and `in_ready` returns 1 one cycle after the first pop.
5. **Reset mid-stream.** Stimulus: assert `reset` asynchronously with `fill_level`=4 and 2 words buffered. Required response: all outputs are at reset values before the next clock edge; the subsequent beats of scenario 1 reproduce 0xAB, 0x31, 0xFC.
6. **Clear versus pop.** Stimulus: `clear` asserted while `out_valid`&`out_ready`. Required response: FIFO empty, `word_count`=0, `overflow`=0 on the next cycle; no stale word appears.
